// File: rtl/addr_stream_checker_if.sv
// AXI-stream beat channel between the address generator and its checker.
interface addr_stream_checker_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] tdata;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/addr_stream_checker.sv
// Stream sink that checks for an incrementing data sequence and periodic TLAST framing,
// with optional LFSR-driven backpressure and error status capture.
//
// state | meaning
// ------+---------------------------------------------------------------
// SYNC  | waiting for the first accepted beat to seed the expected value
// LOCK  | every accepted beat is compared against data and TLAST prediction
module addr_stream_checker #(
    parameter int          DATA_W     = 32,
    parameter int          LAST_EVERY = 1,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter bit          RESYNC     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  bp_en,
    input  logic [3:0]            bp_thresh,
    addr_stream_checker_if.slave  s0_axis,
    output logic                  locked,
    output logic [31:0]           beat_cnt,
    output logic [15:0]           err_cnt,
    output logic                  err_flag,
    output logic [DATA_W-1:0]     first_err_exp,
    output logic [DATA_W-1:0]     first_err_got
);

    typedef enum logic {SYNC, LOCK} state_t;

    localparam logic [15:0] LAST_M1 = 16'(LAST_EVERY - 1);

    state_t            state_q, state_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic              tready_q, tready_d;
    logic [31:0]       beat_cnt_q, beat_cnt_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic              err_flag_q, err_flag_d;
    logic [DATA_W-1:0] first_exp_q, first_exp_d;
    logic [DATA_W-1:0] first_got_q, first_got_d;
    logic [DATA_W-1:0] expected_q, expected_d;
    logic [15:0]       last_ctr_q, last_ctr_d;

    logic              accept;
    logic              last_exp;
    logic              data_err;
    logic              last_err;
    logic [15:0]       last_adv;
    logic [15:0]       last_resync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SYNC;
            lfsr_q      <= LFSR_SEED;
            tready_q    <= 1'b0;
            beat_cnt_q  <= '0;
            err_cnt_q   <= '0;
            err_flag_q  <= 1'b0;
            first_exp_q <= '0;
            first_got_q <= '0;
            expected_q  <= '0;
            last_ctr_q  <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            tready_q    <= tready_d;
            beat_cnt_q  <= beat_cnt_d;
            err_cnt_q   <= err_cnt_d;
            err_flag_q  <= err_flag_d;
            first_exp_q <= first_exp_d;
            first_got_q <= first_got_d;
            expected_q  <= expected_d;
            last_ctr_q  <= last_ctr_d;
        end
    end

    always_comb begin
        accept      = s0_axis.tvalid & tready_q;
        last_exp    = (last_ctr_q == LAST_M1);
        data_err    = (s0_axis.tdata != expected_q);
        last_err    = (s0_axis.tlast != last_exp);
        last_adv    = last_exp ? 16'd0 : last_ctr_q + 16'd1;
        // A beat carrying TLAST closes a frame; anything else is taken as the first beat of one.
        last_resync = (s0_axis.tlast || (LAST_EVERY == 1)) ? 16'd0 : 16'd1;

        state_d     = state_q;
        lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        tready_d    = ~bp_en | (lfsr_q[3:0] >= bp_thresh);
        beat_cnt_d  = beat_cnt_q;
        err_cnt_d   = err_cnt_q;
        err_flag_d  = err_flag_q;
        first_exp_d = first_exp_q;
        first_got_d = first_got_q;
        expected_d  = expected_q;
        last_ctr_d  = last_ctr_q;

        if (clear) begin
            state_d     = SYNC;
            beat_cnt_d  = '0;
            err_cnt_d   = '0;
            err_flag_d  = 1'b0;
            first_exp_d = '0;
            first_got_d = '0;
            expected_d  = '0;
            last_ctr_d  = '0;
        end else if (accept) begin
            beat_cnt_d = beat_cnt_q + 32'd1;
            case (state_q)
                SYNC: begin
                    expected_d = s0_axis.tdata + 1'b1;
                    last_ctr_d = last_resync;
                    state_d    = LOCK;
                end
                LOCK: begin
                    if (data_err || last_err) begin
                        if (err_cnt_q != 16'hFFFF) begin
                            err_cnt_d = err_cnt_q + 16'd1;
                        end
                        if (!err_flag_q) begin
                            first_exp_d = expected_q;
                            first_got_d = s0_axis.tdata;
                        end
                        err_flag_d = 1'b1;
                        expected_d = RESYNC ? s0_axis.tdata + 1'b1 : expected_q + 1'b1;
                        last_ctr_d = (RESYNC && last_err) ? last_resync : last_adv;
                    end else begin
                        expected_d = expected_q + 1'b1;
                        last_ctr_d = last_adv;
                    end
                end
                default: state_d = SYNC;
            endcase
        end
    end

    assign s0_axis.tready = tready_q;
    assign locked         = (state_q == LOCK);
    assign beat_cnt       = beat_cnt_q;
    assign err_cnt        = err_cnt_q;
    assign err_flag       = err_flag_q;
    assign first_err_exp  = first_exp_q;
    assign first_err_got  = first_got_q;

endmodule

// File: tb/tb_addr_stream_checker.sv
// Directed bench for addr_stream_checker: three instances cover RESYNC on/off and TLAST period 4.
module tb_addr_stream_checker;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        bp_en;
    logic [3:0]  bp_thresh;

    logic [31:0] td [3];
    logic        tl [3];
    logic        tv [3];
    logic [2:0]  tr;

    logic        locked   [3];
    logic [31:0] beat_cnt [3];
    logic [15:0] err_cnt  [3];
    logic        err_flag [3];
    logic [31:0] fexp     [3];
    logic [31:0] fgot     [3];

    int n_chk;
    int n_err;
    int wait_total;

    // Instance 0: RESYNC=1, TLAST every beat; 1: RESYNC=0; 2: RESYNC=0, TLAST every 4th beat.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        addr_stream_checker_if #(.DATA_W(32)) axis ();

        assign axis.tdata  = td[g];
        assign axis.tlast  = tl[g];
        assign axis.tvalid = tv[g];
        assign tr[g]       = axis.tready;

        addr_stream_checker #(
            .DATA_W     (32),
            .LAST_EVERY (g == 2 ? 4 : 1),
            .LFSR_SEED  (16'hACE1),
            .RESYNC     (g == 0 ? 1'b1 : 1'b0)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .clear         (clear),
            .bp_en         (bp_en),
            .bp_thresh     (bp_thresh),
            .s0_axis       (axis),
            .locked        (locked[g]),
            .beat_cnt      (beat_cnt[g]),
            .err_cnt       (err_cnt[g]),
            .err_flag      (err_flag[g]),
            .first_err_exp (fexp[g]),
            .first_err_got (fgot[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered at a falling edge; returns at the falling edge after the accepting edge.
    task automatic send(input int i, input logic [31:0] d, input logic l);
        int n;
        n = 0;
        td[i] = d;
        tl[i] = l;
        tv[i] = 1'b1;
        while (!tr[i] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("hs_wait_bounded", 64'(n < 100), 64'd1);
        wait_total += n;
        @(negedge clk);
        tv[i] = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        int hs, ones, toggles, zeros;
        logic [31:0] d;
        logic prev;

        n_chk = 0;
        n_err = 0;
        wait_total = 0;
        rst = 1'b0;
        clear = 1'b0;
        bp_en = 1'b0;
        bp_thresh = 4'd0;
        for (int i = 0; i < 3; i++) begin
            td[i] = '0;
            tl[i] = 1'b0;
            tv[i] = 1'b0;
        end

        #12;
        chk("rst_tready", 64'(tr[0]), 64'd0);
        chk("rst_locked", 64'(locked[0]), 64'd0);
        chk("rst_beat_cnt", 64'(beat_cnt[0]), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt[0]), 64'd0);
        chk("rst_err_flag", 64'(err_flag[0]), 64'd0);
        chk("rst_first_exp", 64'(fexp[0]), 64'd0);
        chk("rst_first_got", 64'(fgot[0]), 64'd0);

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("tready_after_rst", 64'(tr[0]), 64'd1);

        // 100-beat clean count-up
        for (int k = 0; k < 100; k++) send(0, 32'(k), 1'b1);
        chk("seq100_beat_cnt", 64'(beat_cnt[0]), 64'd100);
        chk("seq100_err_cnt", 64'(err_cnt[0]), 64'd0);
        chk("seq100_locked", 64'(locked[0]), 64'd1);
        chk("seq100_no_stall", 64'(wait_total), 64'd0);

        // wrap through all-ones
        do_clear();
        chk("clear_locked", 64'(locked[0]), 64'd0);
        send(0, 32'hFFFF_FFFE, 1'b1);
        send(0, 32'hFFFF_FFFF, 1'b1);
        send(0, 32'h0000_0000, 1'b1);
        send(0, 32'h0000_0001, 1'b1);
        chk("wrap_beat_cnt", 64'(beat_cnt[0]), 64'd4);
        chk("wrap_err_cnt", 64'(err_cnt[0]), 64'd0);
        chk("wrap_err_flag", 64'(err_flag[0]), 64'd0);

        // data gap with resync
        do_clear();
        send(0, 32'd5, 1'b1);
        send(0, 32'd6, 1'b1);
        send(0, 32'd9, 1'b1);
        send(0, 32'd10, 1'b1);
        chk("resync_err_cnt", 64'(err_cnt[0]), 64'd1);
        chk("resync_err_flag", 64'(err_flag[0]), 64'd1);
        chk("resync_first_exp", 64'(fexp[0]), 64'd7);
        chk("resync_first_got", 64'(fgot[0]), 64'd9);
        send(0, 32'd11, 1'b1);
        chk("resync_next_ok", 64'(err_cnt[0]), 64'd1);
        chk("resync_beat_cnt", 64'(beat_cnt[0]), 64'd5);

        // data gap without resync
        send(1, 32'd5, 1'b1);
        send(1, 32'd6, 1'b1);
        send(1, 32'd9, 1'b1);
        send(1, 32'd10, 1'b1);
        chk("nosync_err_cnt", 64'(err_cnt[1]), 64'd2);
        chk("nosync_first_exp", 64'(fexp[1]), 64'd7);
        chk("nosync_first_got", 64'(fgot[1]), 64'd9);

        // TLAST period 4, TLAST on beats 4 and 7
        for (int k = 0; k < 8; k++) send(2, 32'(k), (k == 3 || k == 6));
        chk("frame_err_cnt", 64'(err_cnt[2]), 64'd2);
        chk("frame_err_flag", 64'(err_flag[2]), 64'd1);
        chk("frame_first_exp", 64'(fexp[2]), 64'd6);
        chk("frame_first_got", 64'(fgot[2]), 64'd6);
        chk("frame_beat_cnt", 64'(beat_cnt[2]), 64'd8);

        // random backpressure, TVALID held for 1000 cycles
        do_clear();
        bp_en = 1'b1;
        bp_thresh = 4'd8;
        @(negedge clk);
        hs = 0;
        ones = 0;
        toggles = 0;
        d = 32'h1234_0000;
        prev = tr[0];
        td[0] = d;
        tl[0] = 1'b1;
        tv[0] = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            if (tr[0] != prev) toggles++;
            prev = tr[0];
            if (tr[0]) begin
                hs++;
                ones++;
                d = d + 32'd1;
            end
            @(negedge clk);
            td[0] = d;
        end
        tv[0] = 1'b0;
        @(negedge clk);
        chk("bp_toggles", 64'(toggles > 10), 64'd1);
        chk("bp_some_stall", 64'(ones < 1000), 64'd1);
        chk("bp_beat_cnt", 64'(beat_cnt[0]), 64'(hs));
        chk("bp_err_cnt", 64'(err_cnt[0]), 64'd0);

        bp_thresh = 4'd0;
        @(negedge clk);
        @(negedge clk);
        zeros = 0;
        for (int c = 0; c < 30; c++) begin
            if (!tr[0]) zeros++;
            @(negedge clk);
        end
        chk("thresh0_always_ready", 64'(zeros), 64'd0);
        bp_en = 1'b0;
        @(negedge clk);

        // clear coinciding with an accepted beat, after an error
        do_clear();
        send(0, 32'd40, 1'b1);
        send(0, 32'd45, 1'b1);
        chk("pre_clear_err_flag", 64'(err_flag[0]), 64'd1);
        td[0] = 32'd46;
        tl[0] = 1'b1;
        tv[0] = 1'b1;
        clear = 1'b1;
        chk("clear_hs_ready", 64'(tr[0]), 64'd1);
        @(negedge clk);
        clear = 1'b0;
        tv[0] = 1'b0;
        chk("clear_beat_cnt", 64'(beat_cnt[0]), 64'd0);
        chk("clear_err_cnt", 64'(err_cnt[0]), 64'd0);
        chk("clear_err_flag", 64'(err_flag[0]), 64'd0);
        chk("clear_first_exp", 64'(fexp[0]), 64'd0);
        chk("clear_locked2", 64'(locked[0]), 64'd0);
        send(0, 32'd500, 1'b1);
        send(0, 32'd501, 1'b1);
        chk("post_clear_locked", 64'(locked[0]), 64'd1);
        chk("post_clear_beat_cnt", 64'(beat_cnt[0]), 64'd2);
        chk("post_clear_err_cnt", 64'(err_cnt[0]), 64'd0);

        // reset mid-stream
        send(0, 32'd502, 1'b1);
        rst = 1'b0;
        #1;
        chk("midrst_beat_cnt", 64'(beat_cnt[0]), 64'd0);
        chk("midrst_locked", 64'(locked[0]), 64'd0);
        chk("midrst_tready", 64'(tr[0]), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send(0, 32'd900, 1'b1);
        send(0, 32'd901, 1'b1);
        chk("post_rst_beat_cnt", 64'(beat_cnt[0]), 64'd2);
        chk("post_rst_err_cnt", 64'(err_cnt[0]), 64'd0);
        chk("post_rst_locked", 64'(locked[0]), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
